write_buffer: RTL
=================

// Module: write_buffer
// PURPOSE
//  Store FIFO between dcache access logic and the memory arbiter. Takes dWEN/daddr/daccessstore
//  from access logic, acks each store in the same cycle, drains entries to memory in order.
//  Forwards youngest matching store data to reads and drives wempty back to access logic,
//  which uses it for halt/flush completion and LL/SC ordering.
// PARAMETERS
//  DEPTH      4   entries; power of two, >= 2
//  PTR_W      $clog2(DEPTH)   derived pointer width; do not override
// PORTS
//  CLK         in   1    system clock, rising edge
//  nRST        in   1    asynchronous active-low reset
//  dWEN        in   1    store request from access logic
//  daddr       in   32   store/read address (word_t), word aligned
//  daccessstore in  32   store data (word_t)
//  dREN        in   1    read request from access logic (forward lookup only)
//  wack        out  1    store accepted this cycle (= dWEN & !full)
//  full        out  1    count == DEPTH
//  wempty      out  1    count == 0 and no drain in flight
//  fhit        out  1    dREN & some valid entry address == daddr
//  fdata       out  32   data of youngest matching entry; 0 when !fhit
//  rpri        in   1    arbiter: read pending, do not start a new drain
//  ramWEN      out  1    drain write request to arbiter
//  ramaddr     out  32   head entry address
//  ramstore    out  32   head entry data
//  dwait       in   1    memory busy; write completes in cycle dwait==0 with ramWEN==1
// BEHAVIOUR
//  Reset: all entries invalid, head=tail=count=0, FSM IDLE; outputs wack=0, full=0, wempty=1,
//   fhit=0, fdata=0, ramWEN=0, ramaddr=0, ramstore=0. Reset mid-drain drops all contents.
//  Push: on wack, entry[tail] <= {daddr, daccessstore}, tail+1 mod DEPTH, count+1 at next edge.
//  Full: dWEN with full -> wack=0, nothing written; access logic holds request. No bypass of
//   a same-cycle pop into a full buffer (push seen next cycle).
//  Drain FSM (2 states):
//   IDLE : count!=0 & !rpri -> DRAIN. Else stay.
//   DRAIN: ramWEN=1, ramaddr/ramstore = entry[head], held stable. dwait==0 -> pop head
//          (head+1, count-1); next = IDLE. rpri ignored once in DRAIN (no abort).
//   Min store-to-memory latency: push cycle N, DRAIN in N+1, done earliest N+1 if dwait low.
//  Simultaneous push+pop: count unchanged, both pointers advance; legal when full is 0.
//  Forwarding: combinational compare daddr vs all valid entries; youngest (closest to tail)
//   wins. Entry being popped this cycle still counts as valid. A store pushed this cycle is
//   not visible until next cycle.
//  wempty: 1 only when count==0 and state==IDLE; falls the cycle after the first push.
//  Pointers wrap modulo DEPTH; count is PTR_W+1 bits and never exceeds DEPTH.
// STRUCTURE
//  cpu_types_pkg: word_t (existing); add wb_entry_t {word_t addr; word_t data;} and
//   wb_state_t enum {WB_IDLE, WB_DRAIN}.
//  write_buffer_if.vh: interface with modports wb and tb, matching the port list above.
//  Single module; forward match is a for-loop priority scan, no sub-module needed.
// TESTING
//  1. Reset with dWEN=1 held: wack=0 during reset, wempty=1, ramWEN=0 after release until push.
//  2. Push A=0x100/0xAAAA, dwait=0, rpri=0: ramWEN=1 next cycle with 0x100/0xAAAA; wempty=1 one
//     cycle after completion.
//  3. dwait=1, push 4 stores 0x10..0x1C: full=1 after 4th; 5th dWEN gives wack=0; drop dwait
//     -> drained in order 0x10,0x14,0x18,0x1C, each held stable while dwait=1.
//  4. Push 0x40/1 then 0x40/2 with dwait=1; dREN daddr=0x40 -> fhit=1, fdata=2; daddr=0x44
//     -> fhit=0, fdata=0.
//  5. rpri=1 with count=2: ramWEN stays 0; rpri=0 -> drain begins next cycle; raise rpri
//     mid-DRAIN -> current write still completes.
//  6. Assert nRST low during DRAIN with count=3: next edge-independent ramWEN=0, wempty=1,
//     fhit=0 for previously stored addresses.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared cpu word type plus write buffer entry and drain state types
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t addr;
    word_t data;
  } wb_entry_t;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_DRAIN = 1'b1
  } wb_state_t;

endpackage

// File: rtl/write_buffer_if.sv
// rtl/write_buffer_if.sv - bundle of write buffer signals with design and bench views
interface write_buffer_if
  import cpu_types_pkg::*;
(
  input logic CLK,
  input logic nRST
);
  logic  dWEN;
  word_t daddr;
  word_t daccessstore;
  logic  dREN;
  logic  wack;
  logic  full;
  logic  wempty;
  logic  fhit;
  word_t fdata;
  logic  rpri;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  logic  dwait;

  modport wb (
    input  CLK, nRST, dWEN, daddr, daccessstore, dREN, rpri, dwait,
    output wack, full, wempty, fhit, fdata, ramWEN, ramaddr, ramstore
  );

  modport tb (
    input  CLK, nRST, wack, full, wempty, fhit, fdata, ramWEN, ramaddr, ramstore,
    output dWEN, daddr, daccessstore, dREN, rpri, dwait
  );
endinterface

// File: rtl/write_buffer.sv
// rtl/write_buffer.sv - in-order store FIFO between dcache access logic and memory arbiter
module write_buffer
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t daccessstore,
  input  logic  dREN,
  output logic  wack,
  output logic  full,
  output logic  wempty,
  output logic  fhit,
  output word_t fdata,
  input  logic  rpri,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  logic  dwait
);

  wb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] idx;
  wb_state_t        state, next_state;
  logic             push, pop;

  assign full   = (count == (PTR_W+1)'(DEPTH));
  // Gated by reset so a held store request is never acknowledged while in reset.
  assign wack   = dWEN & ~full & nRST;
  assign push   = wack;
  assign pop    = (state == WB_DRAIN) & ~dwait;
  assign wempty = (count == '0) & (state == WB_IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= WB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A push into an empty buffer may start draining next cycle; the head slot is written on that edge.
  always_comb begin
    next_state = state;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    case (state)
      WB_IDLE: begin
        if ((count != '0 || push) && !rpri) next_state = WB_DRAIN;
      end
      WB_DRAIN: begin
        ramWEN   = 1'b1;
        ramaddr  = entries[head].addr;
        ramstore = entries[head].data;
        if (!dwait) next_state = WB_IDLE;
      end
      default: next_state = WB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (push) begin
        entries[tail] <= '{addr: daddr, data: daccessstore};
        tail          <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Scan oldest to youngest so the last match, the youngest store, wins.
  always_comb begin
    fhit  = 1'b0;
    fdata = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (dREN && ((PTR_W+1)'(k) < count) && (entries[idx].addr == daddr)) begin
        fhit  = 1'b1;
        fdata = entries[idx].data;
      end
    end
  end

endmodule
